bin2bcd_seq: RTL and testbench

- Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter, one bit per clock.
- Sits directly upstream of the two-digit BCD adder. It turns binary operands (0..127) into the packed 8-bit BCD form (tens in [7:4], units in [3:0]) that the adder consumes on a/b.
- Values above 99 raise ovf; s then carries value mod 100.

---
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble binary-to-BCD converter, one bit per clock.
//   Produces the packed two-digit BCD form {tens, units} for the downstream
//   BCD adder. Values above 99 raise ovf, and s then carries value mod 100.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  conversion request, accepted only while ready=1
//   bin    unsigned binary operand, sampled on the accept edge only
//   ready  high in IDLE, the converter can accept start
//   valid  one-cycle pulse, s/ovf hold the new result
//   s      packed BCD result {tens, units}, held until the next valid
//   ovf    hundreds digit nonzero (bin > 99), held with s
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | one add-3/shift step per cycle, BIN_W cycles total
// DONE  | valid=1 for one cycle, s/ovf already registered

module bin2bcd_seq #(
  parameter int BIN_W      = 7,
  parameter int width_low  = 4,
  parameter int width_high = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [width_high-1:0] s,
  output logic                  ovf
);

  localparam int BCD_W = 3 * width_low;
  localparam int CAT_W = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;   // {hundreds, tens, units}
  logic [2:0]       cnt_q;

  logic [BCD_W-1:0] bcd_adj;
  logic [CAT_W-1:0] cat_sh;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             last_step;

  function automatic logic [width_low-1:0] add3(input logic [width_low-1:0] d);
    return (d >= width_low'(5)) ? d + width_low'(3) : d;
  endfunction

  // All three digits are corrected from pre-shift values, then the whole
  // {BCD, binary} chain moves left so the binary MSB lands in units[0].
  always_comb begin
    bcd_adj   = {add3(bcd_q[3*width_low-1:2*width_low]),
                 add3(bcd_q[2*width_low-1:width_low]),
                 add3(bcd_q[width_low-1:0])};
    cat_sh    = {bcd_adj, bin_q} << 1;
    bcd_shift = cat_sh[CAT_W-1:BIN_W];
    bin_shift = cat_sh[BIN_W-1:0];
  end

  assign last_step = (state_q == SHIFT) && (cnt_q == 3'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      s     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= bin;
            bcd_q <= '0;
            cnt_q <= 3'(BIN_W);
          end
        end
        SHIFT: begin
          bin_q <= bin_shift;
          bcd_q <= bcd_shift;
          cnt_q <= cnt_q - 3'd1;
          // Result is captured on the edge entering DONE so it is stable
          // for the whole valid cycle.
          if (last_step) begin
            s   <= bcd_shift[width_high-1:0];
            ovf <= |bcd_shift[3*width_low-1:2*width_low];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [6:0] bin;
  logic       ready;
  logic       valid;
  logic [7:0] s;
  logic       ovf;

  int errors;
  int checks;

  logic [7:0] last_s;
  logic       last_ovf;

  bin2bcd_seq #(.BIN_W(7), .width_low(4), .width_high(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .valid (valid),
    .s     (s),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] bin;
    logic [7:0] s;
    logic       ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits from plain arithmetic.
  function automatic logic [8:0] ref_conv(input int v);
    int t;
    int u;
    t = (v % 100) / 10;
    u = v % 10;
    return {(v >= 100) ? 1'b1 : 1'b0, 4'(t), 4'(u)};
  endfunction

  // Decimal model of the downstream BCD adder: {cout, sum}.
  function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b);
    int x;
    x = int'(a[7:4]) * 10 + int'(a[3:0]) + int'(b[7:4]) * 10 + int'(b[3:0]);
    return {(x >= 100) ? 1'b1 : 1'b0, 4'((x % 100) / 10), 4'(x % 10)};
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // Issue one conversion in the current (ready) cycle, scramble bin while
  // busy, and report latency, busy length, valid count and hold behaviour.
  task automatic convert(input logic [6:0] v, output logic [7:0] s_o, output logic ovf_o,
                         output int lat, output int busy, output int nvalid, output logic hold_bad);
    wait_ready();
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start    = 1'b0;
    bin      = 7'($urandom);
    lat      = 0;
    busy     = 0;
    nvalid   = 0;
    hold_bad = 1'b0;
    s_o      = 8'hxx;
    ovf_o    = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      if (ready !== 1'b1) busy++;
      if (valid === 1'b1) begin
        nvalid++;
        if (lat == 0) begin
          lat   = c;
          s_o   = s;
          ovf_o = ovf;
        end
      end else if (lat == 0 && (s !== last_s || ovf !== last_ovf)) begin
        hold_bad = 1'b1;
      end
      if (ready === 1'b1) break;
      @(negedge clk);
      bin = 7'($urandom);
    end
    last_s   = s_o;
    last_ovf = ovf_o;
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] rs;
    logic       ro;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       hb;
    logic [8:0] exp9;
    int         lat;
    int         busy;
    int         nv;
    int         vc;

    errors = 0;
    checks = 0;

    vecs[0] = '{7'd45,  8'h45, 1'b0};
    vecs[1] = '{7'd0,   8'h00, 1'b0};
    vecs[2] = '{7'd99,  8'h99, 1'b0};
    vecs[3] = '{7'd100, 8'h00, 1'b1};
    vecs[4] = '{7'd127, 8'h27, 1'b1};
    vecs[5] = '{7'd5,   8'h05, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_s",     {24'd0, s},     32'h00);
    chk("rst_ovf",   {31'd0, ovf},   32'd0);
    last_s   = 8'h00;
    last_ovf = 1'b0;

    // Table vectors, issued back-to-back in the first ready cycle.
    for (int i = 0; i < 6; i++) begin
      convert(vecs[i].bin, rs, ro, lat, busy, nv, hb);
      chk($sformatf("vec%0d_s", i),      {24'd0, rs}, {24'd0, vecs[i].s});
      chk($sformatf("vec%0d_ovf", i),    {31'd0, ro}, {31'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_lat", i),    lat,         32'd8);
      chk($sformatf("vec%0d_busy", i),   busy,        32'd8);
      chk($sformatf("vec%0d_nvalid", i), nv,          32'd1);
      chk($sformatf("vec%0d_hold", i),   {31'd0, hb}, 32'd0);
    end

    // Start while busy is ignored; bin scrambled every cycle.
    wait_ready();
    start = 1'b1;
    bin   = 7'd37;
    @(negedge clk);
    start = 1'b0;
    bin   = 7'($urandom);
    @(negedge clk);
    start = 1'b1;
    bin   = 7'd12;
    @(negedge clk);
    start = 1'b0;
    vc = 0;
    rs = 8'hxx;
    for (int c = 0; c < 20; c++) begin
      bin = 7'($urandom);
      if (valid === 1'b1) begin
        vc++;
        rs = s;
        ro = ovf;
      end
      @(negedge clk);
    end
    chk("busy_start_nvalid", vc, 32'd1);
    chk("busy_start_s", {24'd0, rs}, 32'h37);
    chk("busy_start_ovf", {31'd0, ro}, 32'd0);
    chk("busy_start_idle", {31'd0, ready}, 32'd1);
    last_s   = s;
    last_ovf = ovf;

    // Reset on the 4th SHIFT cycle aborts the conversion.
    wait_ready();
    start = 1'b1;
    bin   = 7'd88;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_s",     {24'd0, s},     32'h00);
    chk("abort_ovf",   {31'd0, ovf},   32'd0);
    vc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid === 1'b1) vc++;
    end
    chk("abort_no_valid", vc, 32'd0);
    last_s   = 8'h00;
    last_ovf = 1'b0;
    convert(7'd5, rs, ro, lat, busy, nv, hb);
    chk("after_abort_s", {24'd0, rs}, 32'h05);

    // Reset dominates a simultaneous start.
    rst_n = 1'b0;
    start = 1'b1;
    bin   = 7'd50;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("rst_dom_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);
    chk("rst_dom_ready2", {31'd0, ready}, 32'd1);
    last_s   = 8'h00;
    last_ovf = 1'b0;

    // Exhaustive sweep against the decimal model.
    for (int v = 0; v < 128; v++) begin
      convert(7'(v), rs, ro, lat, busy, nv, hb);
      exp9 = ref_conv(v);
      chk($sformatf("sweep%0d", v), {23'd0, ro, rs}, {23'd0, exp9});
    end

    // Random-order conversions.
    for (int i = 0; i < 24; i++) begin
      int v;
      v = int'($urandom_range(0, 127));
      convert(7'(v), rs, ro, lat, busy, nv, hb);
      exp9 = ref_conv(v);
      chk($sformatf("rand%0d_v%0d", i, v), {23'd0, ro, rs}, {23'd0, exp9});
      chk($sformatf("rand%0d_lat", i), lat, 32'd8);
    end

    // Converted operands fed through the downstream adder model.
    convert(7'd45, ra, ro, lat, busy, nv, hb);
    convert(7'd38, rb, ro, lat, busy, nv, hb);
    chk("add_45_38", {23'd0, bcd_add(ra, rb)}, 32'h083);
    convert(7'd99, ra, ro, lat, busy, nv, hb);
    convert(7'd99, rb, ro, lat, busy, nv, hb);
    chk("add_99_99", {23'd0, bcd_add(ra, rb)}, 32'h198);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
